mul_cell_sched: RTL and testbench
=================================

# mul_cell_sched

Sequencer and arbiter for the shared 16x16 three-partial-product multiplier cell. Accepts 32x32 unsigned multiply requests from two requesters and grants them round-robin. It drives the cell's operand and enable inputs, combines the registered partial products, and returns either the low or high 32 bits of the 64-bit product. It sits between the CPU-side multiply issue logic (requester 0) and an accelerator port (requester 1) on one side, and the multiplier cell on the other.

## Interface
- No parameters; all widths fixed: operands 32, partial products 32, result 32.
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept strobe; at most one bit set, only in IDLE.
- req_a0, req_b0  in  32 each  requester 0 operands.
- req_a1, req_b1  in  32 each  requester 1 operands.
- req_hi  in  2  per-requester op select: 0 = low word, 1 = high word (unsigned).
- resp_valid  out  1  one-cycle result strobe; no backpressure.
- resp_id  out  1  requester the result belongs to.
- resp_data  out  32  result word.
- busy  out  1  high whenever state != IDLE.
- cell_src1, cell_src2  out  32 each  cell operands.
- cell_en  out  1  cell pipeline enable.
- cell_p1, cell_p2, cell_p3  in  32 each  cell products: p1 = src1[15:0]*src2[15:0], p2 = src1[15:0]*src2[31:16], p3 = src1[31:16]*src2[15:0]. Registered inside the cell with one cycle of latency after cell_en; held while cell_en = 0.

## Operation
- States: IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE.
- IDLE: if any req_valid is set, grant one requester. The grant is a handshake: req_ready[g] = 1 in the same cycle, combinational from state, req_valid and last_grant. Latch a, b, hi, id = g; set last_grant = g; go to ISSUE1. With no valid request, stay in IDLE.
- Arbitration: round-robin. When both requesters are valid, grant the one that is not last_grant; a single valid requester always wins.
- ISSUE1: cell_src1 = a, cell_src2 = b, cell_en = 1; go to WAIT1.
- WAIT1: acc (50 bits) = p1 + (p2 << 16) + (p3 << 16), with no truncation. If hi = 0, go to DONE with result = acc[31:0]; otherwise go to ISSUE2.
- ISSUE2: cell_src1 = {16'h0, a[31:16]}, cell_src2 = {16'h0, b[31:16]}, cell_en = 1; go to WAIT2.
- WAIT2: result = (acc[49:32] zero-extended + p1) mod 2^32, i.e. a_hi*b_hi is added to the carry-out of the low partial sums; go to DONE.
- DONE: resp_valid = 1, resp_id = id, resp_data = result; go to IDLE. New requests are not accepted in DONE.
- cell_en = 0 in every state except ISSUE1 and ISSUE2. cell_src1/cell_src2 = 0 when not issuing.
- Operand inputs are sampled only in the accept cycle. Later changes on req_* have no effect on an operation in flight.

## Timing
- Reset values: state = IDLE, req_ready = 0 (no valid), resp_valid = 0, resp_id = 0, resp_data = 0, busy = 0, cell_en = 0, cell_src1/cell_src2 = 0. last_grant = 1, so requester 0 wins the first contended grant.
- Low-word latency: accept at cycle T, resp_valid at T+3. Throughput is one op per 4 cycles.
- High-word latency: accept at T, resp_valid at T+5. Throughput is one op per 6 cycles.
- The earliest next accept is the cycle after DONE.
- resp_data/resp_id hold their last value between strobes; only resp_valid qualifies them.
- Reset asserted mid-operation: return to IDLE next cycle, drop the operation with no resp_valid, cell_en = 0. The requester must reissue.
- A requester that keeps valid high after a grant is treated as a new request and is re-arbitrated in the next IDLE.

## Test plan
- Single low op: req0 a = 3, b = 5, hi = 0 at cycle T -> req_ready = 2'b01 at T, resp_valid at T+3, resp_id = 0, resp_data = 0x0000000F.
- High-word carry: req1 a = b = 0xFFFFFFFF, hi = 1 -> resp at T+5, resp_id = 1, resp_data = 0xFFFFFFFE. The same operands with hi = 0 -> 0x00000001.
- Cross-half product: a = b = 0x00010000 -> low = 0x00000000, high = 0x00000001. Also a = 0x12345678, b = 0x9ABCDEF0 -> low = 0x242D2080, high = 0x0B00EA4E.
- Contention: both valid from reset, each held after grant -> grants alternate 0,1,0,1. Each requester's resp_id matches its grant, with no starvation over 8 ops.
- Cell enable discipline: across a high op, cell_en is high in exactly 2 cycles (T+1, T+3) and cell_src is zero otherwise.
- Reset mid-op: assert reset in WAIT2 -> busy = 0 next cycle, no resp_valid. A fresh request then completes with correct data.

Source files
------------

// File: rtl/mul_cell_sched.sv
// Round-robin sequencer for the shared 16x16 three-partial-product multiplier cell.
// Builds a 32x32 unsigned product in one (low word) or two (high word) cell passes.
module mul_cell_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [31:0] req_a0,
    input  logic [31:0] req_b0,
    input  logic [31:0] req_a1,
    input  logic [31:0] req_b1,
    input  logic [1:0]  req_hi,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [31:0] resp_data,
    output logic        busy,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE1 = 3'd1,
        WAIT1  = 3'd2,
        ISSUE2 = 3'd3,
        WAIT2  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state, state_next;
    logic [31:0] a_q, b_q;
    logic        hi_q, id_q, last_grant;
    logic [17:0] carry_q;
    logic [31:0] data_q;
    logic        resp_id_q;

    logic        grant_valid;
    logic        grant;
    logic [49:0] acc_sum;
    logic [31:0] hi_sum;

    always_comb begin
        grant_valid = |req_valid;
        if (&req_valid) begin
            grant = ~last_grant;
        end else begin
            grant = req_valid[1];
        end
    end

    // Low pass: full 50-bit sum of the three partials; high pass adds a_hi*b_hi to its carry-out.
    assign acc_sum = {18'b0, cell_p1} + {2'b0, cell_p2, 16'b0} + {2'b0, cell_p3, 16'b0};
    assign hi_sum  = {14'b0, carry_q} + cell_p1;

    always_comb begin
        state_next = state;
        req_ready  = 2'b00;
        cell_en    = 1'b0;
        cell_src1  = 32'h0;
        cell_src2  = 32'h0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    req_ready  = grant ? 2'b10 : 2'b01;
                    state_next = ISSUE1;
                end
            end
            ISSUE1: begin
                cell_en    = 1'b1;
                cell_src1  = a_q;
                cell_src2  = b_q;
                state_next = WAIT1;
            end
            WAIT1: begin
                state_next = hi_q ? ISSUE2 : DONE;
            end
            ISSUE2: begin
                cell_en    = 1'b1;
                cell_src1  = {16'h0, a_q[31:16]};
                cell_src2  = {16'h0, b_q[31:16]};
                state_next = WAIT2;
            end
            WAIT2: begin
                state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            a_q        <= 32'h0;
            b_q        <= 32'h0;
            hi_q       <= 1'b0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
            carry_q    <= 18'h0;
            data_q     <= 32'h0;
            resp_id_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant_valid) begin
                a_q        <= grant ? req_a1 : req_a0;
                b_q        <= grant ? req_b1 : req_b0;
                hi_q       <= req_hi[grant];
                id_q       <= grant;
                last_grant <= grant;
            end
            // Result registers change only when a result is produced, so they hold between strobes.
            if (state == WAIT1) begin
                carry_q <= acc_sum[49:32];
                if (!hi_q) begin
                    data_q    <= acc_sum[31:0];
                    resp_id_q <= id_q;
                end
            end
            if (state == WAIT2) begin
                data_q    <= hi_sum;
                resp_id_q <= id_q;
            end
        end
    end

    assign busy       = (state != IDLE);
    assign resp_valid = (state == DONE);
    assign resp_id    = resp_id_q;
    assign resp_data  = data_q;

endmodule

// File: tb/tb_mul_cell_sched.sv
// Self-checking bench for mul_cell_sched: directed table, contention and reset sequences,
// plus randomized traffic checked cycle by cycle against a timing/arithmetic reference model.
module tb_mul_cell_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_hi;
    logic        resp_valid;
    logic        resp_id;
    logic [31:0] resp_data;
    logic        busy;
    logic [31:0] cell_src1, cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1, cell_p2, cell_p3;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mul_cell_sched dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_hi     (req_hi),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .busy       (busy),
        .cell_src1  (cell_src1),
        .cell_src2  (cell_src2),
        .cell_en    (cell_en),
        .cell_p1    (cell_p1),
        .cell_p2    (cell_p2),
        .cell_p3    (cell_p3)
    );

    // Multiplier cell: registered partial products, held while disabled.
    initial begin
        cell_p1 = 32'h0;
        cell_p2 = 32'h0;
        cell_p3 = 32'h0;
    end
    always @(posedge clk) begin
        if (cell_en) begin
            cell_p1 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[15:0]};
            cell_p2 <= {16'h0, cell_src1[15:0]}  * {16'h0, cell_src2[31:16]};
            cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one op in flight at a time, described by grant cycle, operands and product.
    int          cyc      = 0;
    int          busy_end = 0;
    bit          op_active = 0;
    int          g_cyc;
    bit          m_lg = 1;
    bit          m_id, m_hi, g, m_idle, exp_rv, exp_en;
    logic [31:0] m_a, m_b, m_exp, es1, es2;
    logic [63:0] prod;
    logic [1:0]  exp_ready;
    logic [31:0] last_data = 32'h0;
    bit          last_id   = 0;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            op_active = 0;
            busy_end  = cyc;
            m_lg      = 1;
            last_data = 32'h0;
            last_id   = 0;
        end else begin
            m_idle    = (cyc > busy_end);
            exp_ready = 2'b00;
            g         = 0;
            if (m_idle && req_valid != 2'b00) begin
                g         = (req_valid == 2'b11) ? ~m_lg : req_valid[1];
                exp_ready = g ? 2'b10 : 2'b01;
            end
            chk("req_ready", req_ready, exp_ready);
            chk("busy", busy, !m_idle);

            exp_en = 0; es1 = 32'h0; es2 = 32'h0;
            if (op_active && cyc == g_cyc + 1) begin
                exp_en = 1; es1 = m_a; es2 = m_b;
            end else if (op_active && m_hi && cyc == g_cyc + 3) begin
                exp_en = 1; es1 = {16'h0, m_a[31:16]}; es2 = {16'h0, m_b[31:16]};
            end
            chk("cell_en", cell_en, exp_en);
            chk("cell_src1", cell_src1, es1);
            chk("cell_src2", cell_src2, es2);

            exp_rv = op_active && (cyc == busy_end);
            chk("resp_valid", resp_valid, exp_rv);
            if (exp_rv) begin
                chk("resp_id", resp_id, m_id);
                chk("resp_data", resp_data, m_exp);
                last_data = m_exp;
                last_id   = m_id;
                op_active = 0;
            end else begin
                chk("resp_data hold", resp_data, last_data);
                chk("resp_id hold", resp_id, last_id);
            end

            if (exp_ready != 2'b00) begin
                m_id      = g;
                m_a       = g ? req_a1 : req_a0;
                m_b       = g ? req_b1 : req_b0;
                m_hi      = req_hi[g];
                prod      = {32'h0, m_a} * {32'h0, m_b};
                m_exp     = m_hi ? prod[63:32] : prod[31:0];
                g_cyc     = cyc;
                busy_end  = cyc + (m_hi ? 5 : 3);
                m_lg      = g;
                op_active = 1;
            end
        end
    end

    typedef struct {
        bit          id;
        logic [31:0] a;
        logic [31:0] b;
        bit          hi;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[7];

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int k;
        int en_cnt;
        bit got;
        @(posedge clk); #1;
        if (v.id) begin
            req_a1 = v.a; req_b1 = v.b;
        end else begin
            req_a0 = v.a; req_b0 = v.b;
        end
        req_hi[v.id] = v.hi;
        req_valid    = v.id ? 2'b10 : 2'b01;
        @(negedge clk);
        chk({nm, " accept"}, req_ready, v.id ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        req_a0 = 32'hDEAD_BEEF; req_b0 = 32'hDEAD_BEEF;
        req_a1 = 32'hDEAD_BEEF; req_b1 = 32'hDEAD_BEEF;
        req_hi = ~req_hi;
        k = 0; en_cnt = 0; got = 0;
        while (!got && k < 12) begin
            @(negedge clk);
            k++;
            if (cell_en) en_cnt++;
            if (resp_valid) begin
                got = 1;
                chk({nm, " data"}, resp_data, v.exp);
                chk({nm, " id"}, resp_id, v.id);
                chk({nm, " latency"}, k, v.hi ? 5 : 3);
                chk({nm, " cell_en count"}, en_cnt, v.hi ? 2 : 1);
            end
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: no resp_valid within 12 cycles", nm);
        end
    endtask

    initial begin
        int ngrant, nresp, k;
        bit gl[$];
        bit rl[$];

        reset = 1'b1; req_valid = 2'b00; req_hi = 2'b00;
        req_a0 = 32'h0; req_b0 = 32'h0; req_a1 = 32'h0; req_b1 = 32'h0;

        tbl[0] = '{0, 32'h3,        32'h5,        0, 32'h0000_000F};
        tbl[1] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE};
        tbl[2] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32'h0000_0001};
        tbl[3] = '{0, 32'h0001_0000, 32'h0001_0000, 0, 32'h0000_0000};
        tbl[4] = '{0, 32'h0001_0000, 32'h0001_0000, 1, 32'h0000_0001};
        tbl[5] = '{1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 32'h242D_2080};
        tbl[6] = '{0, 32'h1234_5678, 32'h9ABC_DEF0, 1, 32'h0B00_EA4E};

        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset resp_valid", resp_valid, 0);
        chk("reset resp_data", resp_data, 0);
        chk("reset cell_en", cell_en, 0);

        for (int i = 0; i < 7; i++) begin
            run_op(tbl[i], $sformatf("tbl%0d", i));
        end

        // Both requesters held valid from reset: grants must alternate starting with requester 0.
        do_reset();
        req_a0 = 32'h0001_2345; req_b0 = 32'h0000_0010; req_a1 = 32'hFFFF_0001; req_b1 = 32'h8000_0003;
        req_hi = 2'b10;
        req_valid = 2'b11;
        ngrant = 0; nresp = 0; k = 0;
        while (ngrant < 8 && k < 100) begin
            @(negedge clk);
            k++;
            if (req_ready != 2'b00) begin
                gl.push_back(req_ready[1]);
                ngrant++;
            end
            if (resp_valid) rl.push_back(resp_id);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid) rl.push_back(resp_id);
        end
        chk("contention grant count", ngrant, 8);
        chk("contention resp count", rl.size(), 8);
        for (int i = 0; i < gl.size(); i++) chk($sformatf("contention grant%0d", i), gl[i], i % 2);
        for (int i = 0; i < rl.size(); i++) chk($sformatf("contention resp_id%0d", i), rl[i], i % 2);

        // Reset during WAIT2 of a high-word op: op is dropped silently.
        @(posedge clk); #1;
        req_a1 = 32'hFFFF_FFFF; req_b1 = 32'hFFFF_FFFF; req_hi = 2'b10; req_valid = 2'b10;
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midop busy before reset", busy, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midop busy after reset", busy, 0);
        chk("midop resp_valid", resp_valid, 0);
        @(negedge clk);
        chk("midop resp_valid late", resp_valid, 0);
        run_op(tbl[6], "post reset");

        // Randomized traffic, checked by the reference model.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            req_valid = 2'($urandom_range(0, 3));
            req_hi    = 2'($urandom_range(0, 3));
            req_a0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            req_b0 = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            req_a1 = $urandom;
            req_b1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
